add_initiator: RTL and testbench

Request-side driver for the one-cycle-latency adder datapath (`start`/`a`/`b` in, `valid`/`y` out). Accepts operand pairs over a ready/valid upstream port, issues a single-cycle `start` pulse with registered operands, waits for the adder's `valid`, and returns the sum, or a timeout error, over a ready/valid downstream port. Sits between a command source and the adder, and serves as the transmitter for that protocol.

---
 rtl/add_initiator.sv | 124 ++++++++++++
 tb/tb_add_initiator.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/add_initiator.sv
// Request-side driver for a one-cycle-latency adder: ready/valid operands in,
// start pulse out, sum or timeout error back out. Optional checker: ADD_INIT_CHECK_EN.
module add_initiator #(
  parameter int W       = 16,
  parameter int TIMEOUT = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_a,
  input  logic [W-1:0] in_b,
  output logic         start,
  output logic [W-1:0] a,
  output logic [W-1:0] b,
  input  logic         valid,
  input  logic [W-1:0] y,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_sum,
  output logic         out_err,
  output logic [7:0]   spur_cnt
`ifdef ADD_INIT_CHECK_EN
  ,
  output logic [7:0]   mis_cnt
`endif
);

  // state | meaning
  // IDLE  | ready for an operand pair
  // ISSUE | start pulse to the adder
  // WAIT  | waiting for adder valid, counting toward timeout
  // HOLD  | result presented downstream until out_ready
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] wait_cnt;
  logic       timed_out;
  logic       mismatch;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  assign timed_out = (wait_cnt == LAST_CNT);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_nxt = ISSUE;
      end
      ISSUE: state_nxt = WAIT;
      WAIT:  if (valid || timed_out) state_nxt = HOLD;
      HOLD:  if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef ADD_INIT_CHECK_EN
  logic [W-1:0] sum_ref;
  assign sum_ref  = a + b;
  assign mismatch = (y != sum_ref);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) mis_cnt <= '0;
    else if (state == WAIT && valid && mismatch && mis_cnt != 8'hFF)
      mis_cnt <= mis_cnt + 8'd1;
  end
`else
  assign mismatch = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      start     <= 1'b0;
      a         <= '0;
      b         <= '0;
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_err   <= 1'b0;
      wait_cnt  <= '0;
      spur_cnt  <= '0;
    end else begin
      if (valid && state != WAIT && spur_cnt != 8'hFF)
        spur_cnt <= spur_cnt + 8'd1;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a     <= in_a;
            b     <= in_b;
            start <= 1'b1;
          end
        end
        ISSUE: begin
          start    <= 1'b0;
          wait_cnt <= '0;
        end
        WAIT: begin
          // valid wins over a timeout landing on the same edge
          if (valid) begin
            out_sum   <= y;
            out_err   <= mismatch;
            out_valid <= 1'b1;
          end else if (timed_out) begin
            out_sum   <= '0;
            out_err   <= 1'b1;
            out_valid <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_add_initiator.sv
// Directed self-checking bench for add_initiator; adder responses are driven
// by hand with precomputed sums.
module tb_add_initiator;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic        start;
  logic [15:0] a, b;
  logic        valid = 1'b0;
  logic [15:0] y = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] out_sum;
  logic        out_err;
  logic [7:0]  spur_cnt;
`ifdef ADD_INIT_CHECK_EN
  logic [7:0]  mis_cnt;
`endif

  int n_chk = 0;
  int n_bad = 0;

  add_initiator #(.W(16), .TIMEOUT(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .start(start), .a(a), .b(b),
    .valid(valid), .y(y),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_err(out_err),
    .spur_cnt(spur_cnt)
`ifdef ADD_INIT_CHECK_EN
    , .mis_cnt(mis_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // accept operands, then return yv from the adder one cycle after start
  task automatic op_to_hold(input logic [15:0] ia, input logic [15:0] ib, input logic [15:0] yv);
    in_a = ia; in_b = ib; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    valid = 1'b1; y = yv;
    step();
    valid = 1'b0;
  endtask

  task automatic release_hold();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    step();
    step();
    rst = 1'b0;
    #2;
    check("rst_in_ready", in_ready, 1);
    check("rst_start", start, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_a", a, 0);
    check("rst_spur", spur_cnt, 0);

    // basic 3 + 5 with cycle-by-cycle timing
    in_a = 16'h0003; in_b = 16'h0005; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("e0_start", start, 1);
    check("e0_a", a, 16'h0003);
    check("e0_b", b, 16'h0005);
    check("e0_in_ready", in_ready, 0);
    step();
    check("e1_start", start, 0);
    check("e1_out_valid", out_valid, 0);
    valid = 1'b1; y = 16'h0008;
    step();
    valid = 1'b0;
    check("e2_out_valid", out_valid, 1);
    check("e2_out_sum", out_sum, 16'h0008);
    check("e2_out_err", out_err, 0);
    check("e2_in_ready", in_ready, 0);
    release_hold();
    check("e3_out_valid", out_valid, 0);
    check("e3_in_ready", in_ready, 1);

    // wrap
    op_to_hold(16'hFFFF, 16'h0002, 16'h0001);
    check("wrap_sum", out_sum, 16'h0001);
    check("wrap_err", out_err, 0);
    release_hold();

    // timeout: WAIT entered at E1, error at E5
    in_a = 16'h0007; in_b = 16'h0009; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    step();
    check("to_early_valid", out_valid, 0);
    step();
    check("to_out_valid", out_valid, 1);
    check("to_err", out_err, 1);
    check("to_sum", out_sum, 0);
    check("to_spur", spur_cnt, 0);
    release_hold();

    // backpressure with a new operand pending
    op_to_hold(16'h1234, 16'h1111, 16'h2345);
    in_a = 16'h00AA; in_b = 16'h0055; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("bp_out_valid", out_valid, 1);
      check("bp_sum", out_sum, 16'h2345);
      check("bp_in_ready", in_ready, 0);
      check("bp_a", a, 16'h1234);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    check("bp_rel_valid", out_valid, 0);
    check("bp_rel_in_ready", in_ready, 1);
    check("bp_rel_start", start, 0);
    step();
    in_valid = 1'b0;
    check("bp_next_start", start, 1);
    check("bp_next_a", a, 16'h00AA);
    check("bp_next_b", b, 16'h0055);
    step();
    valid = 1'b1; y = 16'h00FF;
    step();
    valid = 1'b0;
    check("bp_next_sum", out_sum, 16'h00FF);
    release_hold();

    // spurious valids in IDLE
    for (int i = 0; i < 3; i++) begin
      valid = 1'b1;
      step();
      valid = 1'b0;
      step();
    end
    check("spur_cnt3", spur_cnt, 3);

    // async reset while start is high
    in_a = 16'h0004; in_b = 16'h0004; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    check("pre_rst_start", start, 1);
    rst = 1'b1;
    #1;
    check("rst_issue_start", start, 0);
    check("rst_issue_in_ready", in_ready, 1);
    check("rst_issue_spur", spur_cnt, 0);
    rst = 1'b0;
    valid = 1'b1;
    step();
    valid = 1'b0;
    check("late_valid_spur", spur_cnt, 1);

    // async reset while holding a result
    op_to_hold(16'h0001, 16'h0001, 16'h0002);
    check("pre_rst_out_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("rst_hold_out_valid", out_valid, 0);
    check("rst_hold_in_ready", in_ready, 1);
    rst = 1'b0;
    step();

    // adder returns a wrong sum
    op_to_hold(16'h0003, 16'h0005, 16'h0009);
    check("bad_sum", out_sum, 16'h0009);
`ifdef ADD_INIT_CHECK_EN
    check("bad_err", out_err, 1);
    check("mis_cnt", mis_cnt, 1);
`else
    check("bad_err", out_err, 0);
`endif
    release_hold();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
